// File: rtl/db_arbiter.sv
// db_arbiter: shares the CPU's single data-break channel between two break
// devices (port 0 = RK8E disk controller, port 1 = secondary break device).
// One request per port is accepted, grants alternate round-robin, and the
// DB1 major state is watched to find the end of the break cycle. On a read,
// memory data is captured and returned on rdata with a one-clock ack pulse.
//
// Requester handshake: reqN is a level. The requester raises reqN with
// addrN/wrN/wdataN valid and holds it until it sees ackN (break completed)
// or errN (no DB1 within TIMEOUT clocks). It then drops reqN at once, and
// may raise it again for a new transfer no earlier than the following clock.
// Fields are sampled only on the grant edge; a dropped req does not cancel a
// granted break.
module db_arbiter #(
  parameter logic [4:0]  DB1_CODE = 5'd10,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  state,
  input  logic        break_in_prog,
  input  logic        req0,
  input  logic [14:0] addr0,
  input  logic        wr0,
  input  logic [11:0] wdata0,
  input  logic        req1,
  input  logic [14:0] addr1,
  input  logic        wr1,
  input  logic [11:0] wdata1,
  input  logic [11:0] mem_rdata,
  output logic        data_break,
  output logic [14:0] break_addr,
  output logic        to_mem,
  output logic [11:0] break_wdata,
  output logic [11:0] rdata,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // The counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_ACK  = 2'd3
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic          last_q, last_d;     // port granted most recently
  logic          gnt_q, gnt_d;       // port owning the current break
  logic          mask_q, mask_d;     // first IDLE clock after an ack
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic [14:0]   addr_q, addr_d;
  logic          tomem_q, tomem_d;
  logic [11:0]   wdata_q, wdata_d;
  logic [11:0]   rdata_q, rdata_d;
  logic          cap_q, cap_d;       // first XFER clock: capture read data
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    err_q, err_d;

  logic [1:0]    mask_vec;
  logic [1:0]    elig;
  logic          win;

  // Eligible requests and the round-robin winner among them. The port that
  // was just acked is still dropping its req, so it is masked for one clock.
  always_comb begin
    mask_vec = 2'b00;
    if (mask_q) begin
      mask_vec[gnt_q] = 1'b1;
    end
    elig = {req1, req0} & ~mask_vec;
    win  = last_q;
    if (elig[~last_q]) begin
      win = ~last_q;
    end
  end

  // Next-state and next-output logic for the break sequencer.
  always_comb begin
    fsm_d   = fsm_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    addr_d  = addr_q;
    tomem_d = tomem_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cap_d   = cap_q;
    ack_d   = 2'b00;
    err_d   = 2'b00;

    unique case (fsm_q)
      S_IDLE: begin
        mask_d = 1'b0;
        if (|elig) begin
          addr_d  = win ? addr1  : addr0;
          tomem_d = win ? wr1    : wr0;
          wdata_d = win ? wdata1 : wdata0;
          db_d    = 1'b1;
          gnt_d   = win;
          last_d  = win;
          cnt_d   = '0;
          fsm_d   = S_REQ;
        end
      end

      S_REQ: begin
        if (state == DB1_CODE) begin
          db_d  = 1'b0;
          cap_d = 1'b1;
          fsm_d = S_XFER;
        end else if (cnt_q == CNT_LAST) begin
          db_d         = 1'b0;
          err_d[gnt_q] = 1'b1;
          fsm_d        = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_XFER: begin
        // Memory data is only valid on the first edge after DB1 is seen.
        cap_d = 1'b0;
        if (cap_q && !tomem_q) begin
          rdata_d = mem_rdata;
        end
        if ((state != DB1_CODE) && !break_in_prog) begin
          ack_d[gnt_q] = 1'b1;
          fsm_d        = S_ACK;
        end
      end

      S_ACK: begin
        mask_d = 1'b1;
        fsm_d  = S_IDLE;
      end

      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the break request immediately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q   <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      mask_q  <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      addr_q  <= '0;
      tomem_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cap_q   <= 1'b0;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
    end else begin
      fsm_q   <= fsm_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      addr_q  <= addr_d;
      tomem_q <= tomem_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cap_q   <= cap_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign data_break  = db_q;
  assign break_addr  = addr_q;
  assign to_mem      = tomem_q;
  assign break_wdata = wdata_q;
  assign rdata       = rdata_q;
  assign ack0        = ack_q[0];
  assign ack1        = ack_q[1];
  assign err0        = err_q[0];
  assign err1        = err_q[1];
  assign busy        = (fsm_q != S_IDLE);
  assign dbg_state   = fsm_q;

endmodule

// File: tb/tb_db_arbiter.sv
// Bench for db_arbiter: two requester agents, a CPU break responder that
// also holds the reference model, and a completion monitor that pops the
// expected-event queue.
`timescale 1ns/1ps
module tb_db_arbiter;

  localparam logic [4:0] DB1 = 5'd10;
  localparam int         TO  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- DUT signals ----------------
  logic [4:0]  state;
  logic        bip;
  logic [11:0] mem_rdata;
  logic        req0, wr0, req1, wr1;
  logic [14:0] addr0, addr1;
  logic [11:0] wdata0, wdata1;
  logic        data_break, to_mem, ack0, ack1, err0, err1, busy;
  logic [14:0] break_addr;
  logic [11:0] break_wdata, rdata;
  logic [1:0]  dbg_state;

  db_arbiter #(.DB1_CODE(DB1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .state(state), .break_in_prog(bip),
    .req0(req0), .addr0(addr0), .wr0(wr0), .wdata0(wdata0),
    .req1(req1), .addr1(addr1), .wr1(wr1), .wdata1(wdata1),
    .mem_rdata(mem_rdata), .data_break(data_break), .break_addr(break_addr),
    .to_mem(to_mem), .break_wdata(break_wdata), .rdata(rdata),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] exp_q[$];          // {kind(1=ack,2=err), 1'b0, port, rdata}
  int          grant_log[$];

  // test configuration (written by the stimulus process only)
  int          job_target[2];
  logic        cfg_rand;
  logic [14:0] cfg_addr[2];
  logic        cfg_wr[2];
  logic [11:0] cfg_wdata[2];
  logic        cfg_poke[2];
  int          cfg_gap;
  int          cpu_mode;          // 0 respond, 1 never respond, 2 silent, 3 random mix
  int          cfg_dly;
  int          cfg_len;
  logic [11:0] cfg_rd;

  // reference model state (owned by the CPU responder)
  logic        model_last;
  logic [11:0] model_rdata;

  // requester inputs as seen on each rising edge
  logic [1:0]  req_s;
  logic [14:0] a_s[2];
  logic        w_s[2];
  logic [11:0] d_s[2];

  always @(posedge clk) begin
    req_s  <= {req1, req0};
    a_s[0] <= addr0;  a_s[1] <= addr1;
    w_s[0] <= wr0;    w_s[1] <= wr1;
    d_s[0] <= wdata0; d_s[1] <= wdata1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_fields(input logic [14:0] ga, input logic gw, input logic [11:0] gd);
    check("hold_addr", break_addr, ga);
    check("hold_to_mem", to_mem, gw);
    check("hold_wdata", break_wdata, gd);
  endtask

  function automatic logic [4:0] other_state();
    logic [4:0] s;
    if (!cfg_rand) return 5'd0;
    s = 5'($urandom_range(0, 31));
    if (s == DB1) s = s + 5'd1;
    return s;
  endfunction

  // ---------------- requester agents ----------------
  for (genvar g = 0; g < 2; g++) begin : agent
    logic        r;
    logic [14:0] a;
    logic        w;
    logic [11:0] d;
    int          issued;
    logic        done_w;
    assign done_w = (g == 1) ? (ack1 | err1) : (ack0 | err0);

    initial begin
      int got;
      int seen;
      int gap;
      r = 1'b0; a = '0; w = 1'b0; d = '0; issued = 0;
      forever begin
        @(negedge clk);
        if (reset === 1'b1 && issued < job_target[g]) begin
          if (cfg_rand) begin
            a = 15'($urandom_range(0, 32767));
            w = 1'($urandom_range(0, 1));
            d = 12'($urandom_range(0, 4095));
          end else begin
            a = cfg_addr[g]; w = cfg_wr[g]; d = cfg_wdata[g];
          end
          r = 1'b1;
          issued++;
          got = 0;
          seen = 0;
          for (int k = 0; k < 300 && got == 0; k++) begin
            @(negedge clk);
            if (reset !== 1'b1) got = 2;
            else if (done_w) got = 1;
            else if (data_break && seen == 0) seen = 1;
            else if (seen == 1 && cfg_poke[g]) begin
              a = 15'o77777;
              seen = 2;
            end
          end
          r = 1'b0;
          compared++;
          if (got == 0) begin
            mismatched++;
            $display("FAIL agent%0d_wait: got no ack/err expected one within 300 clocks", g);
          end
          gap = cfg_rand ? int'($urandom_range(1, 4)) : cfg_gap;
          repeat (gap) @(negedge clk);
        end
      end
    end
  end

  assign req0 = agent[0].r; assign addr0 = agent[0].a; assign wr0 = agent[0].w; assign wdata0 = agent[0].d;
  assign req1 = agent[1].r; assign addr1 = agent[1].a; assign wr1 = agent[1].w; assign wdata1 = agent[1].d;

  // ---------------- CPU responder + reference model ----------------
  initial begin : cpu
    int w, mode, cnt, dly, len, tail;
    logic [14:0] ga;
    logic        gw;
    logic [11:0] gd, rd;
    logic        db_prev;
    state = 5'd0; bip = 1'b0; mem_rdata = '0;
    model_last = 1'b1; model_rdata = '0; db_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        model_last = 1'b1; model_rdata = '0;
        state = 5'd0; bip = 1'b0; db_prev = 1'b0;
      end else if (data_break && !db_prev) begin
        // round robin: the port other than the last winner has priority
        w = -1;
        if (req_s[!model_last]) w = int'(!model_last);
        else if (req_s[model_last]) w = int'(model_last);
        compared++;
        if (w < 0) begin
          mismatched++;
          $display("FAIL spurious_grant: got data_break=1 expected 0 (no request pending)");
        end else begin
          ga = a_s[w]; gw = w_s[w]; gd = d_s[w];
          check("grant_addr", break_addr, ga);
          check("grant_to_mem", to_mem, gw);
          check("grant_wdata", break_wdata, gd);
          model_last = w[0];
          grant_log.push_back(w);
          mode = (cpu_mode == 3) ? (($urandom_range(0, 5) == 0) ? 1 : 0) : cpu_mode;
          if (mode == 0) begin
            rd = cfg_rand ? 12'($urandom_range(0, 4095)) : cfg_rd;
            if (!gw) model_rdata = rd;
            exp_q.push_back({2'd1, 1'b0, w[0], model_rdata});
            dly  = cfg_rand ? int'($urandom_range(0, 3)) : cfg_dly;
            len  = cfg_rand ? int'($urandom_range(1, 3)) : cfg_len;
            tail = cfg_rand ? int'($urandom_range(0, 1)) : 0;
            for (int i = 0; i < dly; i++) begin
              @(negedge clk);
              check("db_held", data_break, 1);
              check_fields(ga, gw, gd);
            end
            state = DB1; bip = 1'b1; mem_rdata = rd;
            for (int i = 0; i < len; i++) begin
              @(negedge clk);
              check_fields(ga, gw, gd);
            end
            state = other_state();
            if (len >= 2) mem_rdata = 12'($urandom_range(0, 4095));
            for (int i = 0; i < tail; i++) begin
              @(negedge clk);
              check_fields(ga, gw, gd);
            end
            bip = 1'b0;
            @(negedge clk);
            check("ack_latency", (w == 1) ? ack1 : ack0, 1);
            check_fields(ga, gw, gd);
            mem_rdata = 12'($urandom_range(0, 4095));
          end else if (mode == 1) begin
            exp_q.push_back({2'd2, 1'b0, w[0], model_rdata});
            cnt = 1;
            while (cnt < 100) begin
              @(negedge clk);
              if (!data_break) break;
              cnt++;
              check_fields(ga, gw, gd);
            end
            check("db_high_clocks", cnt, TO);
            check("busy_after_timeout", busy, 0);
          end
        end
      end
      db_prev = data_break;
    end
  end

  // ---------------- completion monitor ----------------
  task automatic pop_cmp(input logic [1:0] kind, input logic p);
    logic [15:0] e, act;
    act = {kind, 1'b0, p, rdata};
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL completion: got event %h expected none", act);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        mismatched++;
        $display("FAIL completion: got %h expected %h", act, e);
      end
    end
  endtask

  initial begin : mon
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (ack0) pop_cmp(2'd1, 1'b0);
        if (ack1) pop_cmp(2'd1, 1'b1);
        if (err0) pop_cmp(2'd2, 1'b0);
        if (err1) pop_cmp(2'd2, 1'b1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_quiet(input string name);
    int k;
    k = 0;
    while (k < 3000 && !(agent[0].issued >= job_target[0] && agent[1].issued >= job_target[1] &&
                         !req0 && !req1 && !busy && exp_q.size() == 0)) begin
      @(negedge clk);
      k++;
    end
    compared++;
    if (k >= 3000) begin
      mismatched++;
      $display("FAIL %s_quiet: got busy/pending after 3000 clocks expected idle", name);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin : stim
    int base, k;
    reset = 1'b0;
    job_target[0] = 0; job_target[1] = 0;
    cfg_rand = 1'b0; cfg_gap = 2; cpu_mode = 0; cfg_dly = 0; cfg_len = 2; cfg_rd = '0;
    for (int i = 0; i < 2; i++) begin
      cfg_addr[i] = '0; cfg_wr[i] = 1'b0; cfg_wdata[i] = '0; cfg_poke[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_data_break", data_break, 0);
    check("rst_break_addr", break_addr, 0);
    check("rst_to_mem", to_mem, 0);
    check("rst_break_wdata", break_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ack_err", {ack1, ack0, err1, err0}, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;
    @(negedge clk);

    // single write from port 0
    cfg_addr[0] = 15'o12345; cfg_wr[0] = 1'b1; cfg_wdata[0] = 12'o7070;
    cfg_dly = 0; cfg_len = 2;
    @(posedge clk); job_target[0] += 1;
    @(negedge clk);
    @(negedge clk);
    check("wr_data_break", data_break, 1);
    check("wr_break_addr", break_addr, 15'o12345);
    check("wr_to_mem", to_mem, 1);
    check("wr_break_wdata", break_wdata, 12'o7070);
    wait_quiet("write");

    // read on port 1
    cfg_addr[1] = 15'o00200; cfg_wr[1] = 1'b0; cfg_wdata[1] = 12'o1357; cfg_rd = 12'o4321;
    @(posedge clk); job_target[1] += 1;
    wait_quiet("read");
    check("read_rdata_held", rdata, 12'o4321);

    // contention from reset: both ports always requesting
    pulse_reset();
    base = grant_log.size();
    cfg_addr[0] = 15'o01111; cfg_wr[0] = 1'b1; cfg_wdata[0] = 12'o0101;
    cfg_addr[1] = 15'o02222; cfg_wr[1] = 1'b1; cfg_wdata[1] = 12'o0202;
    cfg_gap = 0; cfg_dly = 3; cfg_len = 1;
    @(posedge clk); job_target[0] += 2; job_target[1] += 2;
    wait_quiet("contention");
    check("rr_count", grant_log.size() - base, 4);
    for (int i = 0; i < 4 && base + i < grant_log.size(); i++) begin
      check("rr_order", grant_log[base + i], i % 2);
    end

    // timeout: CPU never enters DB1
    cfg_gap = 2; cpu_mode = 1;
    @(posedge clk); job_target[0] += 1;
    wait_quiet("timeout");
    check("timeout_busy", busy, 0);

    // reset while the break is pending
    cpu_mode = 2;
    @(posedge clk); job_target[0] += 1;
    k = 0;
    while (k < 20 && !data_break) begin @(negedge clk); k++; end
    check("midrst_granted", data_break, 1);
    @(negedge clk);
    check("midrst_in_req", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_data_break", data_break, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ack_err", {ack1, ack0, err1, err0}, 0);
    check("midrst_rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_quiet", {data_break, ack1, ack0, err1, err0}, 0);
    cpu_mode = 0; cfg_dly = 1; cfg_len = 2; cfg_rd = 12'o0456;
    cfg_addr[1] = 15'o03333; cfg_wr[1] = 1'b0;
    @(posedge clk); job_target[1] += 1;
    @(negedge clk);
    @(negedge clk);
    check("postrst_grant", data_break, 1);
    check("postrst_addr", break_addr, 15'o03333);
    wait_quiet("post_reset");

    // field freeze: addr0 changes one clock after grant
    cfg_addr[0] = 15'o01234; cfg_wr[0] = 1'b1; cfg_wdata[0] = 12'o5555;
    cfg_poke[0] = 1'b1; cfg_dly = 3; cfg_len = 2;
    @(posedge clk); job_target[0] += 1;
    wait_quiet("freeze");
    check("freeze_addr_after", break_addr, 15'o01234);
    cfg_poke[0] = 1'b0;

    // randomized traffic with occasional timeouts
    cfg_rand = 1'b1; cpu_mode = 3;
    @(posedge clk); job_target[0] += 25; job_target[1] += 25;
    wait_quiet("random");

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    mismatched++;
    $display("FAIL watchdog: got simulation still running expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule
